// File: rtl/bd_arbiter.sv
// rtl/bd_arbiter.sv - Two-client round-robin arbiter and sequencer for the MMC block device (optional watchdog: BD_ARB_WATCHDOG_EN)
module bd_arbiter #(
   parameter int TIMEOUT_W = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_req,
   input  logic [1:0]  a_cmd,
   input  logic [23:0] a_addr,
   input  logic        a_rd,
   input  logic        a_wr,
   input  logic [15:0] a_wdata,
   output logic        a_gnt,
   output logic        a_iordy,
   output logic        a_done,
   output logic        a_err,
   input  logic        b_req,
   input  logic [1:0]  b_cmd,
   input  logic [23:0] b_addr,
   input  logic        b_rd,
   input  logic        b_wr,
   input  logic [15:0] b_wdata,
   output logic        b_gnt,
   output logic        b_iordy,
   output logic        b_done,
   output logic        b_err,
   output logic [15:0] rdata,
   output logic [1:0]  bd_cmd,
   output logic [23:0] bd_addr,
   output logic        bd_start,
   output logic        bd_rd,
   output logic        bd_wr,
   output logic [15:0] bd_data_in,
   input  logic        bd_bsy,
   input  logic        bd_rdy,
   input  logic        bd_iordy,
   input  logic        bd_err,
   input  logic [15:0] bd_data_out
);

`ifdef BD_ARB_WATCHDOG_EN
   typedef enum logic [2:0] {IDLE, ARM, START, WAITB, XFER, DONE, RECOVER} state_t;
`else
   typedef enum logic [2:0] {IDLE, ARM, START, WAITB, XFER, DONE} state_t;
`endif

   state_t      state;
   logic [1:0]  cmd_q;
   logic [23:0] addr_q;
   logic        err_q;
   logic        last_b;

   logic        a_ok;
   logic        b_ok;
   logic        a_bad;
   logic        b_bad;
   logic        pick_a;
   logic        pick_b;
   logic        in_xfer;
   logic        err_next;

`ifdef BD_ARB_WATCHDOG_EN
   logic [TIMEOUT_W-1:0] wd_cnt;
   logic                 rec_bsy;
   logic                 wd_run;
   assign wd_run = (state == ARM) || (state == WAITB) || (state == XFER);
`endif

   // Legal requests compete; the client not granted last wins a tie
   assign a_ok   = a_req && (a_cmd != 2'b11);
   assign b_ok   = b_req && (b_cmd != 2'b11);
   assign a_bad  = a_req && (a_cmd == 2'b11);
   assign b_bad  = b_req && (b_cmd == 2'b11);
   assign pick_a = a_ok && (!b_ok || last_b);
   assign pick_b = b_ok && !pick_a;

   // Only the granted client's strobes and data reach the device, and only in XFER
   assign in_xfer    = (state == XFER);
   assign bd_rd      = in_xfer && ((a_gnt && a_rd) || (b_gnt && b_rd));
   assign bd_wr      = in_xfer && ((a_gnt && a_wr) || (b_gnt && b_wr));
   assign bd_data_in = !in_xfer ? 16'h0000 : (a_gnt ? a_wdata : (b_gnt ? b_wdata : 16'h0000));
   assign a_iordy    = a_gnt && bd_iordy;
   assign b_iordy    = b_gnt && bd_iordy;
   assign rdata      = bd_data_out;
   assign err_next   = err_q || bd_err;

   // cmd/addr are held in registers so they stay put the cycle after bd_start
   assign bd_cmd  = cmd_q;
   assign bd_addr = addr_q;

   // Sequencer: grant, start handshake, transfer, completion report
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         a_gnt    <= 1'b0;
         b_gnt    <= 1'b0;
         a_done   <= 1'b0;
         b_done   <= 1'b0;
         a_err    <= 1'b0;
         b_err    <= 1'b0;
         bd_start <= 1'b0;
         cmd_q    <= 2'b00;
         addr_q   <= 24'h000000;
         err_q    <= 1'b0;
         last_b   <= 1'b1;
`ifdef BD_ARB_WATCHDOG_EN
         wd_cnt   <= '0;
         rec_bsy  <= 1'b0;
`endif
      end else begin
         a_done   <= 1'b0;
         b_done   <= 1'b0;
         a_err    <= 1'b0;
         b_err    <= 1'b0;
         bd_start <= 1'b0;
         case (state)
            IDLE: begin
               if (a_bad) begin
                  a_done <= 1'b1;
                  a_err  <= 1'b1;
               end
               if (b_bad) begin
                  b_done <= 1'b1;
                  b_err  <= 1'b1;
               end
               if (pick_a || pick_b) begin
                  a_gnt  <= pick_a;
                  b_gnt  <= pick_b;
                  cmd_q  <= pick_a ? a_cmd : b_cmd;
                  addr_q <= pick_a ? a_addr : b_addr;
                  state  <= ARM;
`ifdef BD_ARB_WATCHDOG_EN
                  wd_cnt <= '0;
`endif
               end
            end
            ARM: begin
               if (!bd_bsy) begin
                  state    <= START;
                  bd_start <= 1'b1;
               end
            end
            START: state <= WAITB;
            WAITB: begin
               if (bd_bsy) state <= XFER;
            end
            XFER: begin
               err_q <= err_next;
               if (!bd_bsy) begin
                  state  <= DONE;
                  a_done <= a_gnt;
                  b_done <= b_gnt;
                  a_err  <= a_gnt && err_next;
                  b_err  <= b_gnt && err_next;
               end
            end
            DONE: begin
               a_gnt  <= 1'b0;
               b_gnt  <= 1'b0;
               err_q  <= 1'b0;
               last_b <= b_gnt;
               cmd_q  <= 2'b00;
               addr_q <= 24'h000000;
               state  <= IDLE;
            end
`ifdef BD_ARB_WATCHDOG_EN
            RECOVER: begin
               wd_cnt <= wd_cnt + 1'b1;
               if (bd_bsy) rec_bsy <= 1'b1;
               if ((rec_bsy && !bd_bsy) || (&wd_cnt)) begin
                  a_gnt  <= 1'b0;
                  b_gnt  <= 1'b0;
                  last_b <= b_gnt;
                  cmd_q  <= 2'b00;
                  addr_q <= 24'h000000;
                  state  <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
`ifdef BD_ARB_WATCHDOG_EN
         if (wd_run) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (&wd_cnt) begin
               state    <= RECOVER;
               a_done   <= a_gnt;
               b_done   <= b_gnt;
               a_err    <= a_gnt;
               b_err    <= b_gnt;
               err_q    <= 1'b0;
               cmd_q    <= 2'b00;
               bd_start <= 1'b1;
               wd_cnt   <= '0;
               rec_bsy  <= 1'b0;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_bd_arbiter.sv
// tb/tb_bd_arbiter.sv - Self-checking bench for bd_arbiter
module tb_bd_arbiter;
`ifdef BD_ARB_WATCHDOG_EN
   localparam int TW = 8;
`else
   localparam int TW = 24;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        a_req, a_rd, a_wr, b_req, b_rd, b_wr;
   logic [1:0]  a_cmd, b_cmd;
   logic [23:0] a_addr, b_addr;
   logic [15:0] a_wdata, b_wdata;
   logic        a_gnt, a_iordy, a_done, a_err;
   logic        b_gnt, b_iordy, b_done, b_err;
   logic [15:0] rdata;
   logic [1:0]  bd_cmd;
   logic [23:0] bd_addr;
   logic        bd_start, bd_rd, bd_wr;
   logic [15:0] bd_data_in;
   logic        bd_bsy, bd_rdy, bd_iordy, bd_err;
   logic [15:0] bd_data_out;

   bd_arbiter #(.TIMEOUT_W(TW)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_cmd(a_cmd), .a_addr(a_addr), .a_rd(a_rd), .a_wr(a_wr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_iordy(a_iordy), .a_done(a_done), .a_err(a_err),
      .b_req(b_req), .b_cmd(b_cmd), .b_addr(b_addr), .b_rd(b_rd), .b_wr(b_wr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_iordy(b_iordy), .b_done(b_done), .b_err(b_err),
      .rdata(rdata), .bd_cmd(bd_cmd), .bd_addr(bd_addr), .bd_start(bd_start),
      .bd_rd(bd_rd), .bd_wr(bd_wr), .bd_data_in(bd_data_in),
      .bd_bsy(bd_bsy), .bd_rdy(bd_rdy), .bd_iordy(bd_iordy), .bd_err(bd_err),
      .bd_data_out(bd_data_out)
   );

   typedef struct {
      logic        a_req;
      logic [1:0]  a_cmd;
      logic [23:0] a_addr;
      logic        b_req;
      logic [1:0]  b_cmd;
      logic [23:0] b_addr;
      int          words;
      int          err_at;
      logic        exp_a;
      logic        exp_b;
      logic        exp_rej;
      logic        exp_err;
   } vec_t;

   vec_t vecs[9];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drives n word cycles in XFER; the other client toggles its strobes to prove isolation
   task automatic xfer_words(input logic is_b, input logic [1:0] cmd, input int n, input int err_at,
                             output int fwd, output int bad);
      logic        rd_s, wr_s;
      logic [15:0] wd;
      fwd = 0;
      bad = 0;
      rd_s = (cmd == 2'b01);
      wr_s = (cmd == 2'b10);
      for (int i = 0; i < n; i++) begin
         wd          = i[15:0];
         bd_iordy    = (i % 3) != 0;
         bd_data_out = ~wd;
         bd_err      = (i == err_at);
         if (!is_b) begin
            a_rd = rd_s; a_wr = wr_s; a_wdata = wd;
            b_rd = i[0]; b_wr = ~i[0]; b_wdata = 16'hDEAD;
         end else begin
            b_rd = rd_s; b_wr = wr_s; b_wdata = wd;
            a_rd = i[0]; a_wr = ~i[0]; a_wdata = 16'hBEEF;
         end
         #1;
         if (bd_rd !== rd_s || bd_wr !== wr_s) bad++;
         if (wr_s && bd_data_in !== wd) bad++;
         if (rdata !== ~wd) bad++;
         if ((is_b ? b_iordy : a_iordy) !== bd_iordy) bad++;
         if ((is_b ? a_iordy : b_iordy) !== 1'b0) bad++;
         if (bd_rd || bd_wr) fwd++;
         tick();
      end
      a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0; bd_err = 0; bd_iordy = 0;
   endtask

   task automatic run_vec(input int k, input vec_t v);
      logic [1:0]  ecmd;
      logic [23:0] eaddr;
      int          fwd, bad;
      ecmd  = v.exp_a ? v.a_cmd : v.b_cmd;
      eaddr = v.exp_a ? v.a_addr : v.b_addr;
      a_req = v.a_req; a_cmd = v.a_cmd; a_addr = v.a_addr;
      b_req = v.b_req; b_cmd = v.b_cmd; b_addr = v.b_addr;
      tick();
      if (v.exp_rej) begin
         check($sformatf("v%0d_rej_done", k), {a_done, a_err, b_done, b_err},
               v.a_req ? 4'b1100 : 4'b0011);
         check($sformatf("v%0d_rej_gnt", k), {a_gnt, b_gnt, bd_start}, 3'b000);
         a_req = 0; b_req = 0;
         tick();
         check($sformatf("v%0d_rej_after", k), {a_gnt, b_gnt, a_done, b_done, bd_start}, 5'b0);
         return;
      end
      check($sformatf("v%0d_gnt", k), {a_gnt, b_gnt, bd_start}, {v.exp_a, v.exp_b, 1'b0});
      if (v.exp_a) b_req = 0; else a_req = 0;
      tick();
      check($sformatf("v%0d_start", k), {bd_start, bd_cmd, bd_addr}, {1'b1, ecmd, eaddr});
      tick();
      check($sformatf("v%0d_hold", k), {bd_start, bd_cmd, bd_addr}, {1'b0, ecmd, eaddr});
      bd_bsy = 1;
      tick();
      xfer_words(v.exp_b, ecmd, v.words, v.err_at, fwd, bad);
      check($sformatf("v%0d_route", k), bad, 0);
      check($sformatf("v%0d_fwd", k), fwd, (ecmd == 2'b01 || ecmd == 2'b10) ? v.words : 0);
      bd_bsy = 0;
      tick();
      check($sformatf("v%0d_done", k), {a_done, a_err, b_done, b_err},
            {v.exp_a, v.exp_a & v.exp_err, v.exp_b, v.exp_b & v.exp_err});
      a_req = 0; b_req = 0;
      tick();
      check($sformatf("v%0d_idle", k), {a_gnt, b_gnt, a_done, b_done}, 4'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int fwd, bad, t, cyc;
      logic wb;
      //          a_req a_cmd a_addr       b_req b_cmd b_addr      words err  ea eb rej err
      vecs[0] = '{1'b1, 2'b01, 24'h000010, 1'b0, 2'b00, 24'h000000, 512, -1,  1, 0, 0, 0};
      vecs[1] = '{1'b0, 2'b00, 24'h000000, 1'b1, 2'b10, 24'h00ABCD, 512, -1,  0, 1, 0, 0};
      vecs[2] = '{1'b1, 2'b01, 24'h123456, 1'b0, 2'b00, 24'h000000, 16,  5,   1, 0, 0, 1};
      vecs[3] = '{1'b1, 2'b01, 24'h000001, 1'b0, 2'b00, 24'h000000, 8,   -1,  1, 0, 0, 0};
      vecs[4] = '{1'b0, 2'b00, 24'h000000, 1'b1, 2'b11, 24'h000777, 0,   -1,  0, 0, 1, 1};
      vecs[5] = '{1'b1, 2'b10, 24'h000100, 1'b1, 2'b01, 24'h000200, 8,   -1,  0, 1, 0, 0};
      vecs[6] = '{1'b1, 2'b10, 24'h000300, 1'b1, 2'b01, 24'h000400, 8,   7,   1, 0, 0, 1};
      vecs[7] = '{1'b1, 2'b00, 24'hFFFFFF, 1'b0, 2'b00, 24'h000000, 4,   -1,  1, 0, 0, 0};
      vecs[8] = '{1'b1, 2'b11, 24'h000055, 1'b0, 2'b00, 24'h000000, 0,   -1,  0, 0, 1, 1};

      reset = 1;
      a_req = 0; a_cmd = 0; a_addr = 0; a_rd = 0; a_wr = 0; a_wdata = 0;
      b_req = 0; b_cmd = 0; b_addr = 0; b_rd = 0; b_wr = 0; b_wdata = 0;
      bd_bsy = 0; bd_rdy = 1; bd_iordy = 0; bd_err = 0; bd_data_out = 0;
      tick();
      tick();
      check("reset_outputs", {a_gnt, b_gnt, a_done, b_done, a_err, b_err, a_iordy, b_iordy,
                              bd_start, bd_rd, bd_wr}, 11'b0);
      check("reset_bus", {bd_cmd, bd_addr, bd_data_in, rdata}, 58'b0);
      reset = 0;
      tick();

      for (int k = 0; k < 9; k++) run_vec(k, vecs[k]);

      // Device busy in ARM delays bd_start; then reset lands mid-transfer
      bd_bsy = 1;
      a_req = 1; a_cmd = 2'b01; a_addr = 24'h000005;
      tick();
      check("armbsy_gnt", a_gnt, 1);
      t = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bd_start) t++;
      end
      check("armbsy_nostart", t, 0);
      bd_bsy = 0;
      tick();
      check("armbsy_start", bd_start, 1);
      tick();
      bd_bsy = 1;
      tick();
      xfer_words(1'b0, 2'b01, 2, -1, fwd, bad);
      check("armbsy_fwd", fwd, 2);
      reset = 1;
      a_req = 0;
      tick();
      check("midreset", {a_gnt, b_gnt, a_done, b_done, bd_start, bd_rd, bd_cmd}, 8'b0);
      reset = 0;
      bd_bsy = 0;
      tick();
      tick();
      check("midreset_nodone", {a_gnt, a_done, a_err}, 3'b0);

      // Both clients keep requesting: grants alternate A, B, A, B
      a_req = 1; a_cmd = 2'b01; a_addr = 24'h000100;
      b_req = 1; b_cmd = 2'b10; b_addr = 24'h000200;
      for (int k = 0; k < 4; k++) begin
         t = 0;
         while (!(a_gnt || b_gnt) && t < 10) begin
            tick();
            t++;
         end
         check($sformatf("alt%0d_gnt", k), {a_gnt, b_gnt}, (k % 2 == 1) ? 2'b01 : 2'b10);
         wb = b_gnt;
         tick();
         check($sformatf("alt%0d_start", k), bd_start, 1);
         tick();
         bd_bsy = 1;
         tick();
         xfer_words(wb, wb ? 2'b10 : 2'b01, 6, -1, fwd, bad);
         check($sformatf("alt%0d_route", k), bad, 0);
         bd_bsy = 0;
         tick();
         check($sformatf("alt%0d_done", k), {a_done, b_done}, {~wb, wb});
         if (wb) b_req = 0; else a_req = 0;
         tick();
         if (wb) b_req = 1; else a_req = 1;
      end
      a_req = 0; b_req = 0;
      tick();
      tick();

`ifdef BD_ARB_WATCHDOG_EN
      // Device stuck busy: watchdog reports an error, issues a reset command, then frees the port
      a_req = 1; a_cmd = 2'b10; a_addr = 24'h000042;
      bd_bsy = 1;
      tick();
      check("wd_gnt", a_gnt, 1);
      cyc = 0;
      while (!a_done && cyc < 600) begin
         tick();
         cyc++;
      end
      check("wd_done_err", {a_done, a_err}, 2'b11);
      check("wd_latency", (cyc >= 254 && cyc <= 257), 1);
      check("wd_recover_start", {bd_start, bd_cmd}, 3'b100);
      a_req = 0;
      cyc = 0;
      t = 0;
      tick();
      while (a_gnt && cyc < 600) begin
         if (bd_start) t++;
         tick();
         cyc++;
      end
      check("wd_released", a_gnt, 0);
      check("wd_single_start", t, 0);
      bd_bsy = 0;
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
